uart_tx_arbiter: RTL

//  Shares one RS232 transmitter among N byte requesters (debug monitor, CPU UART port, DMA, ...).

---
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for the shared UART transmitter arbiter.
// The master modport is the arbiter; the slave modport is the requesters plus transmitter.
interface uart_tx_arbiter_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0]   reqValid;
  logic [8*N-1:0] reqData;
  logic [N-1:0]   reqLast;
  logic           lockEn;
  logic [N-1:0]   reqReady;
  logic [N-1:0]   grant;
  logic [7:0]     txData;
  logic           startTX;
  logic           txBusy;
  logic           ackErr;

  modport master (
    input  reqValid, reqData, reqLast, lockEn, txBusy,
    output reqReady, grant, txData, startTX, ackErr
  );

  modport slave (
    output reqValid, reqData, reqLast, lockEn, txBusy,
    input  reqReady, grant, txData, startTX, ackErr
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one RS232 transmitter among N byte requesters, with packet
// lock, level startTX/busy sequencing, minimum startTX low gap and an acknowledge watchdog.
module uart_tx_arbiter #(
  parameter int unsigned N           = 4,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned GAP         = 3
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.master bus
);
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned WdW  = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned GapW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [2:0] {StIdle, StStart, StWaitBusy, StWaitDone, StGap} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   rr_q, rr_d, owner_q, owner_d;
  logic              lock_q, lock_d, last_q, last_d, lock_en_q, lock_en_d;
  logic [N-1:0]      grant_q, grant_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              start_q, start_d, ack_err_q, ack_err_d;
  logic [WdW-1:0]    wd_q, wd_d;
  logic [GapW-1:0]   gap_q, gap_d;

  logic [N-1:0]      elig, owner_oh, pick_oh, ready, grant_out;
  logic [IdxW-1:0]   pick, rr_inc;
  logic              found;
  logic [7:0]        pick_data;

  assign owner_oh = {{(N-1){1'b0}}, 1'b1} << owner_q;
  assign pick_oh  = {{(N-1){1'b0}}, 1'b1} << pick;
  assign rr_inc   = (owner_q == IdxW'(N - 1)) ? '0 : owner_q + 1'b1;

  // First eligible index at or after rr_q, wrapping; lowest offset wins.
  always_comb begin
    elig  = lock_q ? (bus.reqValid & owner_oh) : bus.reqValid;
    found = 1'b0;
    pick  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(rr_q) + k;
      if (j >= int'(N)) j = j - int'(N);
      if (elig[j]) begin
        found = 1'b1;
        pick  = IdxW'(j);
      end
    end
  end

  always_comb begin
    pick_data = 8'h00;
    for (int i = 0; i < N; i++) begin
      if (pick == IdxW'(i)) pick_data = bus.reqData[8*i +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    lock_d    = lock_q;
    last_d    = last_q;
    lock_en_d = lock_en_q;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    start_d   = start_q;
    ack_err_d = 1'b0;
    wd_d      = wd_q;
    ready     = '0;
    grant_out = grant_q;
    // Gap counter measures how long startTX has been low, saturating at GAP.
    if (start_q)                  gap_d = '0;
    else if (gap_q == GapW'(GAP)) gap_d = gap_q;
    else                          gap_d = gap_q + 1'b1;

    case (state_q)
      StIdle: begin
        if (!bus.txBusy && (gap_q == GapW'(GAP)) && found) begin
          owner_d   = pick;
          grant_d   = pick_oh;
          grant_out = pick_oh;
          ready     = pick_oh;
          tx_data_d = pick_data;
          last_d    = bus.reqLast[pick];
          lock_en_d = bus.lockEn;
          state_d   = StStart;
        end
      end
      StStart: begin
        start_d = 1'b1;
        wd_d    = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        wd_d = wd_q + 1'b1;
        if (bus.txBusy) begin
          start_d = 1'b0;
          state_d = StWaitDone;
        end else if (wd_q == WdW'(ACK_TIMEOUT - 1)) begin
          // Dropped byte: release any lock and move on to the next requester.
          start_d   = 1'b0;
          ack_err_d = 1'b1;
          lock_d    = 1'b0;
          rr_d      = rr_inc;
          state_d   = StGap;
        end
      end
      StWaitDone: begin
        if (!bus.txBusy) begin
          state_d = StGap;
          if (lock_en_q && !last_q) begin
            lock_d = 1'b1;
          end else begin
            lock_d = 1'b0;
            rr_d   = rr_inc;
          end
        end
      end
      StGap: begin
        if (gap_q == GapW'(GAP)) begin
          state_d = StIdle;
          if (!lock_q) grant_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      rr_q      <= '0;
      owner_q   <= '0;
      lock_q    <= 1'b0;
      last_q    <= 1'b0;
      lock_en_q <= 1'b0;
      grant_q   <= '0;
      tx_data_q <= 8'h00;
      start_q   <= 1'b0;
      ack_err_q <= 1'b0;
      wd_q      <= '0;
      gap_q     <= GapW'(GAP);
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      lock_q    <= lock_d;
      last_q    <= last_d;
      lock_en_q <= lock_en_d;
      grant_q   <= grant_d;
      tx_data_q <= tx_data_d;
      start_q   <= start_d;
      ack_err_q <= ack_err_d;
      wd_q      <= wd_d;
      gap_q     <= gap_d;
    end
  end

  assign bus.reqReady = ready;
  assign bus.grant    = grant_out;
  assign bus.txData   = tx_data_q;
  assign bus.startTX  = start_q;
  assign bus.ackErr   = ack_err_q;
endmodule
